// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, field positions and slave FSM states for the serial bus
package bus_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int SLAVE_ID_W = 2;
  localparam int ID_MSB = 13;
  localparam int ID_LSB = 12;
  localparam int DATA_START = 6;
  localparam int CNT_W = 5;
  typedef enum logic [2:0] {IDLE, ADDR, WRITE, RDMEM, RESP, SEND, IGNORE} slave_state_e;
endpackage

// File: rtl/slave_mem.sv
// slave_mem: single-port byte RAM with registered read and no content reset
module slave_mem import bus_pkg::*; #(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port: deserialises bus requests, writes or reads local memory and serialises read data back
module bus_slave_port import bus_pkg::*; #(
  parameter logic [SLAVE_ID_W-1:0] SLAVE_ID = 2'b00,
  parameter int                    MEM_AW   = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  input  logic valid_s,
  input  logic write_en,
  input  logic addr_rx,
  input  logic data_rx,
  output logic data_tx,
  output logic slave_valid,
  output logic slave_busy
);
  slave_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, sh_q, sh_d, rdata;
  logic              wr_q, wr_d, tx_q, tx_d, sv_q, sv_d, busy_q;
  slave_mem #(.AW(MEM_AW)) u_mem (
    .clk(clock),
    .we_i(state_q == WRITE && !reset),
    .addr_i(addr_q[MEM_AW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sh_d    = sh_q;
    wr_d    = wr_q;
    tx_d    = 1'b0;
    sv_d    = 1'b0;
    case (state_q)
      IDLE: if (valid && valid_s) begin
        state_d = ADDR;
        cnt_d   = '0;
        wr_d    = write_en;
      end
      ADDR: if (!valid_s) state_d = IDLE;
      else begin
        addr_d  = {addr_q[ADDR_W-2:0], addr_rx};
        wdata_d = cnt_q >= CNT_W'(DATA_START) ? {wdata_q[DATA_W-2:0], data_rx} : wdata_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ADDR_W - 1))
          state_d = addr_d[ID_MSB:ID_LSB] != SLAVE_ID ? IGNORE : wr_q ? WRITE : RDMEM;
      end
      WRITE:  state_d = IDLE;
      RDMEM: begin
        state_d = RESP;
        sv_d    = 1'b1;
      end
      RESP: begin
        state_d = SEND;
        cnt_d   = '0;
        tx_d    = rdata[DATA_W-1];
        sh_d    = {rdata[DATA_W-2:0], 1'b0};
      end
      SEND: begin
        tx_d    = cnt_q == CNT_W'(DATA_W - 1) ? 1'b0 : sh_q[DATA_W-1];
        sh_d    = {sh_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(DATA_W - 1) ? IDLE : SEND;
      end
      IGNORE: state_d = valid_s ? IGNORE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sh_q    <= '0;
      wr_q    <= 1'b0;
      tx_q    <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      tx_q    <= tx_d;
      sv_q    <= sv_d;
      busy_q  <= state_d != IDLE;
    end
  end
  assign data_tx     = tx_q;
  assign slave_valid = sv_q;
  assign slave_busy  = busy_q;
endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: randomized and directed checks of the serial slave against a byte-map model
module tb_bus_slave_port;
  logic clock = 1'b0;
  logic reset = 1'b1, valid = 1'b0, valid_s = 1'b0, write_en = 1'b0, addr_rx = 1'b0, data_rx = 1'b0;
  logic data_tx, slave_valid, slave_busy;
  int errors = 0, checks = 0;
  logic sv_o [0:31];
  logic tx_o [0:31];
  logic busy_o [0:31];
  logic [7:0] ref_mem [logic [11:0]];

  bus_slave_port #(.SLAVE_ID(2'b00), .MEM_AW(12)) dut (
    .clock(clock), .reset(reset), .valid(valid), .valid_s(valid_s), .write_en(write_en),
    .addr_rx(addr_rx), .data_rx(data_rx), .data_tx(data_tx), .slave_valid(slave_valid),
    .slave_busy(slave_busy)
  );

  always #5 clock = ~clock;

  // Cycle k of the loop is cycle T+k; outputs are observed mid-cycle, inputs driven for the next edge.
  task automatic txn(input bit wr, input logic [13:0] a, input logic [7:0] d,
                     input int drop_at, input int rst_at, input int pulse_at, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clock);
      sv_o[k] = slave_valid;
      tx_o[k] = data_tx;
      busy_o[k] = slave_busy;
      reset = (k == rst_at);
      valid = (k == 0) || (k == pulse_at);
      valid_s = (k <= 14) && (drop_at < 0 || k < drop_at);
      write_en = (k == 0) ? wr : 1'($urandom);
      addr_rx = (k >= 1 && k <= 14) ? a[14-k] : 1'($urandom);
      data_rx = (k >= 7 && k <= 14) ? d[14-k] : 1'($urandom);
    end
    reset = 1'b0;
    valid = 1'b0;
    valid_s = 1'b0;
  endtask

  function automatic logic [7:0] rx_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = tx_o[17+i];
    return b;
  endfunction

  function automatic bit sv_ok(input bit expect_resp, input int len);
    bit ok = 1'b1;
    for (int k = 0; k < len; k++) if (sv_o[k] !== (expect_resp && k == 16)) ok = 1'b0;
    return ok;
  endfunction

  function automatic void model_write(input bit wr, input logic [13:0] a, input logic [7:0] d, input bit done);
    if (wr && done && a[13:12] == 2'b00) ref_mem[a[11:0]] = d;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks += 3;
    if (data_tx !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b expected 0", data_tx); end
    if (slave_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b expected 0", slave_valid); end
    if (slave_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", slave_busy); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (slave_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", slave_busy); end
  endtask

  task automatic test_write_read();
    txn(1, 14'h0055, 8'h3C, -1, -1, -1, 16);
    model_write(1, 14'h0055, 8'h3C, 1);
    checks += 2;
    if (!sv_ok(0, 16)) begin errors++; $display("FAIL wr_sv: got slave_valid during write expected none"); end
    if (busy_o[1] !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy_o[1]); end
    txn(0, 14'h0055, 8'h00, -1, -1, -1, 26);
    checks += 5;
    if (!sv_ok(1, 26)) begin errors++; $display("FAIL rd_sv: got sv@16=%b expected single pulse at T+16", sv_o[16]); end
    if (rx_byte() !== ref_mem[12'h055]) begin errors++; $display("FAIL rd_data: got %h expected %h", rx_byte(), ref_mem[12'h055]); end
    if (tx_o[16] !== 1'b0 || tx_o[25] !== 1'b0) begin errors++; $display("FAIL rd_tx_idle: got %b/%b expected 0/0", tx_o[16], tx_o[25]); end
    if (busy_o[24] !== 1'b1) begin errors++; $display("FAIL rd_busy24: got %b expected 1", busy_o[24]); end
    if (busy_o[25] !== 1'b0) begin errors++; $display("FAIL rd_busy25: got %b expected 0", busy_o[25]); end
  endtask

  task automatic test_id_mismatch();
    txn(1, 14'h1055, 8'hFF, -1, -1, -1, 16);
    model_write(1, 14'h1055, 8'hFF, 1);
    checks += 2;
    if (!sv_ok(0, 16)) begin errors++; $display("FAIL mis_wr_sv: got slave_valid expected none"); end
    if (busy_o[16-1] !== 1'b1) begin errors++; $display("FAIL mis_busy: got %b expected 1", busy_o[15]); end
    txn(0, 14'h2055, 8'h00, -1, -1, -1, 26);
    checks += 2;
    if (!sv_ok(0, 26)) begin errors++; $display("FAIL mis_rd_sv: got slave_valid expected none"); end
    if (busy_o[16] !== 1'b0) begin errors++; $display("FAIL mis_rd_busy: got %b expected 0", busy_o[16]); end
    txn(0, 14'h0055, 8'h00, -1, -1, -1, 26);
    checks++;
    if (rx_byte() !== ref_mem[12'h055]) begin errors++; $display("FAIL mis_data: got %h expected %h", rx_byte(), ref_mem[12'h055]); end
  endtask

  task automatic test_abort();
    txn(1, 14'h0010, 8'h5A, -1, -1, -1, 16);
    model_write(1, 14'h0010, 8'h5A, 1);
    txn(1, 14'h0010, 8'hAA, 8, -1, -1, 16);
    model_write(1, 14'h0010, 8'hAA, 0);
    checks += 2;
    if (busy_o[8] !== 1'b1) begin errors++; $display("FAIL abort_busy8: got %b expected 1", busy_o[8]); end
    if (busy_o[9] !== 1'b0) begin errors++; $display("FAIL abort_busy9: got %b expected 0", busy_o[9]); end
    txn(0, 14'h0010, 8'h00, -1, -1, -1, 26);
    checks++;
    if (rx_byte() !== ref_mem[12'h010]) begin errors++; $display("FAIL abort_data: got %h expected %h", rx_byte(), ref_mem[12'h010]); end
  endtask

  task automatic test_reset_mid_send();
    txn(0, 14'h0055, 8'h00, -1, 20, -1, 23);
    checks += 4;
    if (busy_o[20] !== 1'b1) begin errors++; $display("FAIL rst_busy20: got %b expected 1", busy_o[20]); end
    if (tx_o[21] !== 1'b0) begin errors++; $display("FAIL rst_tx: got %b expected 0", tx_o[21]); end
    if (sv_o[21] !== 1'b0) begin errors++; $display("FAIL rst_sv: got %b expected 0", sv_o[21]); end
    if (busy_o[21] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o[21]); end
    txn(0, 14'h0055, 8'h00, -1, -1, -1, 26);
    checks++;
    if (rx_byte() !== ref_mem[12'h055]) begin errors++; $display("FAIL rst_data: got %h expected %h", rx_byte(), ref_mem[12'h055]); end
  endtask

  task automatic test_back_to_back();
    txn(0, 14'h0055, 8'h00, -1, -1, 10, 25);
    checks += 3;
    if (!sv_ok(1, 25)) begin errors++; $display("FAIL b2b_sv: got sv@16=%b expected single pulse at T+16", sv_o[16]); end
    if (rx_byte() !== ref_mem[12'h055]) begin errors++; $display("FAIL b2b_data: got %h expected %h", rx_byte(), ref_mem[12'h055]); end
    if (busy_o[24] !== 1'b1) begin errors++; $display("FAIL b2b_busy24: got %b expected 1", busy_o[24]); end
    txn(0, 14'h0010, 8'h00, -1, -1, -1, 26);
    checks += 3;
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_busy25: got %b expected 0", busy_o[0]); end
    if (!sv_ok(1, 26)) begin errors++; $display("FAIL b2b_next_sv: got sv@16=%b expected single pulse", sv_o[16]); end
    if (rx_byte() !== ref_mem[12'h010]) begin errors++; $display("FAIL b2b_next_data: got %h expected %h", rx_byte(), ref_mem[12'h010]); end
  endtask

  task automatic test_boundary();
    txn(1, 14'h0FFF, 8'h81, -1, -1, -1, 16);
    model_write(1, 14'h0FFF, 8'h81, 1);
    txn(0, 14'h0FFF, 8'h00, -1, -1, -1, 26);
    checks += 2;
    if (!sv_ok(1, 26)) begin errors++; $display("FAIL bnd_sv: got sv@16=%b expected single pulse", sv_o[16]); end
    if (rx_byte() !== ref_mem[12'hFFF]) begin errors++; $display("FAIL bnd_data: got %h expected %h", rx_byte(), ref_mem[12'hFFF]); end
  endtask

  task automatic test_random();
    logic [11:0] pool [6];
    logic [13:0] a;
    logic [7:0] d;
    bit wr;
    for (int i = 0; i < 6; i++) begin
      pool[i] = 12'($urandom);
      d = 8'($urandom);
      txn(1, {2'b00, pool[i]}, d, -1, -1, -1, 16);
      model_write(1, {2'b00, pool[i]}, d, 1);
    end
    for (int n = 0; n < 30; n++) begin
      a = {($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, pool[$urandom_range(0, 5)]};
      d = 8'($urandom);
      wr = 1'($urandom);
      if (wr) begin
        txn(1, a, d, -1, -1, -1, 16);
        model_write(1, a, d, 1);
        checks++;
        if (!sv_ok(0, 16)) begin errors++; $display("FAIL rnd_wr_sv: got slave_valid on write to %h", a); end
      end else begin
        txn(0, a, d, -1, -1, -1, 26);
        checks++;
        if (!sv_ok(a[13:12] == 2'b00, 26)) begin errors++; $display("FAIL rnd_rd_sv: got sv@16=%b for addr %h", sv_o[16], a); end
        if (a[13:12] == 2'b00) begin
          checks++;
          if (rx_byte() !== ref_mem[a[11:0]]) begin errors++; $display("FAIL rnd_rd_data: addr %h got %h expected %h", a, rx_byte(), ref_mem[a[11:0]]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id_mismatch();
    test_abort();
    test_reset_mid_send();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
